// File: rtl/munoc_control_request_arbiter.sv
// Round-robin arbiter that shares the single NoC control/info slave port
// among NUM_REQ requesters. One transaction is outstanding at a time. The
// granted payload is held until the slave answers or the timeout fires. A
// timed-out transaction is answered with an error, then drained until the
// slave finally responds.
module munoc_control_request_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int BW_ADDR        = 32,
  parameter int BW_DATA        = 32,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int BW_REQ_ID      = 4
) (
  input  logic                       clk,
  input  logic                       rstnn,
  input  logic [NUM_REQ-1:0]         req_valid_list,
  input  logic [NUM_REQ-1:0]         req_write_list,
  input  logic [NUM_REQ*BW_ADDR-1:0] req_addr_list,
  input  logic [NUM_REQ*BW_DATA-1:0] req_wdata_list,
  output logic [NUM_REQ-1:0]         req_done_list,
  output logic [BW_DATA-1:0]         rsp_rdata,
  output logic                       rsp_error,
  output logic                       sreq,
  output logic                       swrite,
  output logic [BW_ADDR-1:0]         saddr,
  output logic [BW_DATA-1:0]         swdata,
  output logic [BW_REQ_ID-1:0]       sid,
  input  logic                       sready,
  input  logic [BW_DATA-1:0]         srdata,
  input  logic                       serror,
  output logic [7:0]                 timeout_count
);

  localparam int IDX_BW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TIMER_BW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [TIMER_BW-1:0] TIMER_LAST =
    TIMER_BW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  localparam logic [IDX_BW-1:0] LAST_GRANT_INIT = IDX_BW'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] DONE_ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    RESP  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // Registered state and outputs
  state_t               state_r;
  logic                 sreq_r;
  logic                 swrite_r;
  logic [BW_ADDR-1:0]   saddr_r;
  logic [BW_DATA-1:0]   swdata_r;
  logic [BW_REQ_ID-1:0] sid_r;
  logic [IDX_BW-1:0]    last_grant_r;
  logic [NUM_REQ-1:0]   done_r;
  logic [BW_DATA-1:0]   rdata_r;
  logic                 error_r;
  logic [TIMER_BW-1:0]  timer_r;
  logic                 timed_out_r;
  logic [7:0]           tcount_r;

  // Next-state values
  state_t               state_s;
  logic                 sreq_s;
  logic                 swrite_s;
  logic [BW_ADDR-1:0]   saddr_s;
  logic [BW_DATA-1:0]   swdata_s;
  logic [BW_REQ_ID-1:0] sid_s;
  logic [IDX_BW-1:0]    last_grant_s;
  logic [NUM_REQ-1:0]   done_s;
  logic [BW_DATA-1:0]   rdata_s;
  logic                 error_s;
  logic [TIMER_BW-1:0]  timer_s;
  logic                 timed_out_s;
  logic [7:0]           tcount_s;

  // Arbitration helpers
  logic [BW_ADDR-1:0]   addr_arr_s  [NUM_REQ];
  logic [BW_DATA-1:0]   wdata_arr_s [NUM_REQ];
  logic                 hi_found_s;
  logic                 lo_found_s;
  logic [IDX_BW-1:0]    hi_idx_s;
  logic [IDX_BW-1:0]    lo_idx_s;
  logic                 grant_found_s;
  logic [IDX_BW-1:0]    grant_idx_s;
  int                   last_int_s;
  logic                 timeout_hit_s;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign addr_arr_s[gi]  = req_addr_list[BW_ADDR*gi +: BW_ADDR];
      assign wdata_arr_s[gi] = req_wdata_list[BW_DATA*gi +: BW_DATA];
    end
  endgenerate

  assign timeout_hit_s = TIMEOUT_EN && (timer_r == TIMER_LAST);

  // Round-robin pick: lowest valid index above last_grant, else lowest valid index at or below it
  always_comb begin
    hi_found_s = 1'b0;
    lo_found_s = 1'b0;
    hi_idx_s   = '0;
    lo_idx_s   = '0;
    last_int_s = int'(last_grant_r);
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid_list[i] && (i > last_int_s)) begin
        hi_found_s = 1'b1;
        hi_idx_s   = IDX_BW'(i);
      end else if (req_valid_list[i]) begin
        lo_found_s = 1'b1;
        lo_idx_s   = IDX_BW'(i);
      end else begin
        hi_found_s = hi_found_s;
      end
    end
    grant_found_s = hi_found_s | lo_found_s;
    if (hi_found_s) begin
      grant_idx_s = hi_idx_s;
    end else begin
      grant_idx_s = lo_idx_s;
    end
  end

  // Next-state and next-output logic of the transaction FSM
  always_comb begin
    state_s      = state_r;
    sreq_s       = sreq_r;
    swrite_s     = swrite_r;
    saddr_s      = saddr_r;
    swdata_s     = swdata_r;
    sid_s        = sid_r;
    last_grant_s = last_grant_r;
    done_s       = '0;
    rdata_s      = rdata_r;
    error_s      = error_r;
    timer_s      = timer_r;
    timed_out_s  = timed_out_r;
    tcount_s     = tcount_r;
    case (state_r)
      IDLE: begin
        if (grant_found_s) begin
          state_s      = BUSY;
          sreq_s       = 1'b1;
          swrite_s     = req_write_list[grant_idx_s];
          saddr_s      = addr_arr_s[grant_idx_s];
          swdata_s     = wdata_arr_s[grant_idx_s];
          sid_s        = BW_REQ_ID'(grant_idx_s);
          last_grant_s = grant_idx_s;
          timer_s      = '0;
          timed_out_s  = 1'b0;
        end else begin
          state_s = IDLE;
        end
      end
      BUSY: begin
        if (sready) begin
          // A slave answer in the last timer cycle still counts as a normal response
          state_s = RESP;
          sreq_s  = 1'b0;
          rdata_s = srdata;
          error_s = serror;
          done_s  = DONE_ONE << sid_r;
        end else if (timeout_hit_s) begin
          // Keep sreq high: the slave still owes an answer that must be drained
          state_s     = RESP;
          sreq_s      = 1'b1;
          rdata_s     = '0;
          error_s     = 1'b1;
          timed_out_s = 1'b1;
          done_s      = DONE_ONE << sid_r;
          if (tcount_r != 8'hFF) begin
            tcount_s = tcount_r + 8'd1;
          end else begin
            tcount_s = tcount_r;
          end
        end else begin
          timer_s = timer_r + TIMER_BW'(1);
        end
      end
      RESP: begin
        if (timed_out_r) begin
          state_s = DRAIN;
          sreq_s  = 1'b1;
        end else begin
          state_s = IDLE;
          sreq_s  = 1'b0;
        end
      end
      DRAIN: begin
        if (sready) begin
          state_s     = IDLE;
          sreq_s      = 1'b0;
          timed_out_s = 1'b0;
        end else begin
          state_s = DRAIN;
        end
      end
      default: begin
        state_s     = IDLE;
        sreq_s      = 1'b0;
        timed_out_s = 1'b0;
      end
    endcase
  end

  // State and output registers, cleared asynchronously by rstnn
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      state_r      <= IDLE;
      sreq_r       <= 1'b0;
      swrite_r     <= 1'b0;
      saddr_r      <= '0;
      swdata_r     <= '0;
      sid_r        <= '0;
      last_grant_r <= LAST_GRANT_INIT;
      done_r       <= '0;
      rdata_r      <= '0;
      error_r      <= 1'b0;
      timer_r      <= '0;
      timed_out_r  <= 1'b0;
      tcount_r     <= 8'd0;
    end else begin
      state_r      <= state_s;
      sreq_r       <= sreq_s;
      swrite_r     <= swrite_s;
      saddr_r      <= saddr_s;
      swdata_r     <= swdata_s;
      sid_r        <= sid_s;
      last_grant_r <= last_grant_s;
      done_r       <= done_s;
      rdata_r      <= rdata_s;
      error_r      <= error_s;
      timer_r      <= timer_s;
      timed_out_r  <= timed_out_s;
      tcount_r     <= tcount_s;
    end
  end

  assign req_done_list = done_r;
  assign rsp_rdata     = rdata_r;
  assign rsp_error     = error_r;
  assign sreq          = sreq_r;
  assign swrite        = swrite_r;
  assign saddr         = saddr_r;
  assign swdata        = swdata_r;
  assign sid           = sid_r;
  assign timeout_count = tcount_r;

endmodule

// File: doc/munoc_control_request_arbiter.md
Name: munoc_control_request_arbiter

Overview:
- Shares the single NoC control/info register slave port among NUM_REQ requesters, e.g. the debug bridge, the boot master and the service-ring agent.
- Round-robin arbitration; one outstanding transaction at a time.
- Holds the request payload stable until the slave completes, then returns read data and error to the granted requester.
- A timeout guards against a hung slave; timed-out transactions are answered with an error and then drained.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- BW_ADDR, 32, address width.
- BW_DATA, 32, data width.
- TIMEOUT_CYCLES, 1024, cycles in BUSY before error response; 0 disables timeout.
- BW_REQ_ID, 4, width of requester index forwarded to the slave; must satisfy 2^BW_REQ_ID >= NUM_REQ.

Ports:
- clk  in  1  clock.
- rstnn  in  1  asynchronous active-low reset.
- req_valid_list  in  NUM_REQ  per-requester request; held high until the matching done pulse.
- req_write_list  in  NUM_REQ  1 = write.
- req_addr_list  in  NUM_REQ*BW_ADDR  packed, requester i at [BW_ADDR*(i+1)-1 -: BW_ADDR].
- req_wdata_list  in  NUM_REQ*BW_DATA  packed likewise.
- req_done_list  out  NUM_REQ  one-hot completion pulse.
- rsp_rdata  out  BW_DATA  read data, valid while any done bit is high.
- rsp_error  out  1  error flag, valid while any done bit is high.
- sreq  out  1  slave request.
- swrite  out  1  slave write flag.
- saddr  out  BW_ADDR  slave address.
- swdata  out  BW_DATA  slave write data.
- sid  out  BW_REQ_ID  granted requester index.
- sready  in  1  slave completion pulse.
- srdata  in  BW_DATA  slave read data, sampled with sready.
- serror  in  1  slave error, sampled with sready.
- timeout_count  out  8  saturating count of timeouts.

Behaviour:
- Reset values:
  - state = IDLE.
  - sreq, swrite, req_done_list, rsp_error = 0.
  - saddr, swdata, rsp_rdata, sid = 0.
  - timeout_count = 0.
  - Round-robin pointer last_grant = NUM_REQ-1, so requester 0 wins first.
- State encoding: IDLE, BUSY, RESP, DRAIN.
- IDLE:
  - If any req_valid_list bit is set, grant the first set bit scanning upward from last_grant+1, wrapping modulo NUM_REQ.
  - Register swrite/saddr/swdata/sid from the winner and set last_grant = winner; go to BUSY.
  - If no valid bit is set, stay in IDLE.
- BUSY:
  - sreq = 1; payload registers frozen.
  - Timer counts from 0, incrementing once per BUSY cycle.
  - On sready: capture rsp_rdata = srdata, rsp_error = serror; go to RESP.
  - Else, if TIMEOUT_CYCLES != 0 and timer == TIMEOUT_CYCLES-1: rsp_rdata = 0, rsp_error = 1, set timed_out flag, increment timeout_count (saturating at 255); go to RESP.
  - sready wins over timeout in the same cycle.
- RESP:
  - req_done_list[sid] = 1 for exactly one cycle.
  - If timed_out, go to DRAIN and keep sreq = 1; otherwise sreq = 0 and go to IDLE.
- DRAIN:
  - sreq = 1, payload frozen, no grants, no done pulse.
  - On sready, discard srdata/serror, clear timed_out, go to IDLE.
  - No timeout in DRAIN.
- Latency: valid seen in IDLE at cycle T gives sreq at T+1. sready at cycle T+k gives done at T+k+1. Minimum turnaround is 3 cycles (IDLE, BUSY, RESP).
- Requesters deassert or change valid the cycle after done. The RESP state guarantees the stale valid is not re-granted.
- Requests arriving while not in IDLE wait; there is no queueing beyond each requester's held valid.
- rsp_rdata/rsp_error hold their last values outside RESP.
- Timer width = ceil(log2(TIMEOUT_CYCLES+1)), minimum 1; the timer is cleared on entry to BUSY.
- Reset mid-transaction returns to reset values immediately; no done pulse is issued.
- Out-of-range requester indices cannot be granted.
- sready in IDLE or RESP is ignored.

Test Plan:
- Single read: req 2 valid, addr 0x1000_0010, slave sready after 3 BUSY cycles with srdata 0xCAFE0001 -> sid=2, sreq high 3 cycles, req_done_list=4'b0100 one cycle with rsp_rdata 0xCAFE0001, rsp_error 0.
- Round-robin fairness: all 4 valid continuously, slave always sready in first BUSY cycle -> grant order 0,1,2,3,0,...; each done 3 cycles apart.
- Write pass-through with error: req 1 write, addr 0x1000_0104, wdata 0x5A5A5A5A, serror=1 with sready -> swrite=1, swdata 0x5A5A5A5A, rsp_error=1 on done[1].
- Timeout: TIMEOUT_CYCLES=8, slave silent -> done pulse 8 cycles after BUSY entry with rsp_error=1, rsp_rdata 0, timeout_count=1; req 3 pending stays ungranted until sready arrives in DRAIN, then granted next IDLE cycle.
- Simultaneous sready and timeout on the last timer cycle -> normal response with serror value, timeout_count unchanged, no DRAIN.
- Reset asserted in BUSY -> all outputs 0 immediately, no done pulse; after release requester 0 wins first.
